// File: rtl/hsid_main.sv
`default_nettype none
// ============================================================================
// Module      : hsid_main
// Description : Hyperspectral identification core. Streams one measured pixel
//               spectrum followed by a library of reference spectra (two
//               signed samples per word), computes the MSE of the measure
//               against every library entry and tracks min/max MSE + index.
//               Optional macro HSID_MAIN_SATURATE_EN clamps oversized
//               quotients to all ones instead of truncating them.
// Revision    : 1.0 - initial release
// ============================================================================
module hsid_main #(
    parameter int WORD_WIDTH       = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int DATA_WIDTH_MUL   = 34,
    parameter int DATA_WIDTH_ACC   = 48,
    parameter int HSI_BANDS        = 128,
    parameter int ELEMENTS         = HSI_BANDS / 2,
    parameter int BUFFER_LENGTH    = 16,
    parameter int HSI_LIBRARY_SIZE = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                hsi_vctr_in_valid,
    input  logic [WORD_WIDTH-1:0]               hsi_vctr_in,
    input  logic [$clog2(HSI_LIBRARY_SIZE):0]   library_size_in,
    input  logic [$clog2(HSI_BANDS):0]          hsi_bands_in,
    input  logic                                start,
    input  logic                                clear,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] mse_min_ref,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] mse_max_ref,
    output logic [WORD_WIDTH-1:0]               mse_min_value,
    output logic [WORD_WIDTH-1:0]               mse_max_value,
    output logic                                done,
    output logic                                idle,
    output logic                                ready
);

    localparam int LIB_W   = $clog2(HSI_LIBRARY_SIZE);
    localparam int BAND_W  = $clog2(HSI_BANDS) + 1;
    localparam int ADDR_W  = $clog2(ELEMENTS);
    localparam int FIFO_AW = $clog2(BUFFER_LENGTH);
    localparam int DCNT_W  = $clog2(DATA_WIDTH_ACC);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_READ_MEASURE = 3'd1,
        S_READ_LIB     = 3'd2,
        S_DRAIN        = 3'd3,
        S_DONE         = 3'd4
    } state_t;

    state_t                    r_state, w_next_state;
    logic                      r_start_d;
    logic [BAND_W-1:0]         r_bands, r_words, r_word_cnt;
    logic [LIB_W:0]            r_lib_size, r_lib_cnt;
    logic [DATA_WIDTH_ACC-1:0] r_acc;
    logic [WORD_WIDTH-1:0]     r_meas_buf [0:ELEMENTS-1];

    logic [DATA_WIDTH_ACC-1:0] r_fifo_acc [0:BUFFER_LENGTH-1];
    logic [LIB_W-1:0]          r_fifo_idx [0:BUFFER_LENGTH-1];
    logic [FIFO_AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]          r_fifo_cnt;

    logic                      r_div_busy;
    logic [DCNT_W-1:0]         r_div_cnt;
    logic [DATA_WIDTH_ACC-1:0] r_dq;
    logic [BAND_W-1:0]         r_rem;
    logic [LIB_W-1:0]          r_div_idx;
    logic                      r_cmp_valid;
    logic [WORD_WIDTH-1:0]     r_cmp_mse;
    logic [LIB_W-1:0]          r_cmp_idx;

    // Sign-extend one packed sample to the squared-difference width.
    function automatic logic signed [DATA_WIDTH_MUL-1:0] sext(input logic [DATA_WIDTH-1:0] s);
        return {{(DATA_WIDTH_MUL-DATA_WIDTH){s[DATA_WIDTH-1]}}, s};
    endfunction

    logic                      w_start_pulse, w_accept, w_last_word, w_last_entry;
    logic                      w_fifo_full, w_fifo_empty, w_push, w_pop, w_init_trk;
    logic [WORD_WIDTH-1:0]     w_meas_word;
    logic signed [DATA_WIDTH_MUL-1:0] w_d0, w_d1;
    logic [DATA_WIDTH_MUL-1:0] w_sq0, w_sq1, w_sq1_eff;
    logic [DATA_WIDTH_ACC-1:0] w_acc_next;
    logic [BAND_W:0]           w_rem_sh;
    logic                      w_rem_ge;
    logic [BAND_W-1:0]         w_rem_diff, w_rem_next;
    logic [DATA_WIDTH_ACC-1:0] w_dq_next;
    logic [WORD_WIDTH-1:0]     w_quo_word;

    assign w_start_pulse = start & ~r_start_d;
    assign w_fifo_full   = (r_fifo_cnt == (FIFO_AW+1)'(BUFFER_LENGTH));
    assign w_fifo_empty  = (r_fifo_cnt == '0);
    assign w_accept      = hsi_vctr_in_valid & ready;
    assign w_last_word   = (r_word_cnt == r_words - BAND_W'(1));
    assign w_last_entry  = (r_lib_cnt == r_lib_size - (LIB_W+1)'(1));
    assign w_push        = w_accept & (r_state == S_READ_LIB) & w_last_word;
    assign w_pop         = ~r_div_busy & ~w_fifo_empty;
    assign w_init_trk    = clear | (w_start_pulse & (r_state == S_IDLE));

    // Squared differences of both samples; the upper sample of the final
    // word is dropped when the band count is odd.
    assign w_meas_word = r_meas_buf[r_word_cnt[ADDR_W-1:0]];
    assign w_d0        = sext(hsi_vctr_in[DATA_WIDTH-1:0]) - sext(w_meas_word[DATA_WIDTH-1:0]);
    assign w_d1        = sext(hsi_vctr_in[2*DATA_WIDTH-1:DATA_WIDTH]) - sext(w_meas_word[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign w_sq0       = w_d0 * w_d0;
    assign w_sq1       = w_d1 * w_d1;
    assign w_sq1_eff   = (w_last_word & r_bands[0]) ? '0 : w_sq1;
    assign w_acc_next  = r_acc + {{(DATA_WIDTH_ACC-DATA_WIDTH_MUL){1'b0}}, w_sq0}
                               + {{(DATA_WIDTH_ACC-DATA_WIDTH_MUL){1'b0}}, w_sq1_eff};

    // One restoring-division step: shift in the next dividend bit.
    assign w_rem_sh   = {r_rem, r_dq[DATA_WIDTH_ACC-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_bands});
    assign w_rem_diff = w_rem_sh[BAND_W-1:0] - r_bands;
    assign w_rem_next = w_rem_ge ? w_rem_diff : w_rem_sh[BAND_W-1:0];
    assign w_dq_next  = {r_dq[DATA_WIDTH_ACC-2:0], w_rem_ge};

`ifdef HSID_MAIN_SATURATE_EN
    assign w_quo_word = (|w_dq_next[DATA_WIDTH_ACC-1:WORD_WIDTH]) ? '1 : w_dq_next[WORD_WIDTH-1:0];
`else
    assign w_quo_word = w_dq_next[WORD_WIDTH-1:0];
`endif

    // State register and start edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_d <= start;
        end
    end

    // Next-state and block-level handshake outputs.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        idle         = 1'b0;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                idle = 1'b1;
                if (w_start_pulse) w_next_state = S_READ_MEASURE;
            end
            S_READ_MEASURE: begin
                ready = ~w_fifo_full;
                if (w_accept && w_last_word)
                    w_next_state = (r_lib_size == '0) ? S_DRAIN : S_READ_LIB;
            end
            S_READ_LIB: begin
                ready = ~w_fifo_full;
                if (w_accept && w_last_word && w_last_entry) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_fifo_empty && !r_div_busy && !r_cmp_valid) w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Job configuration, word/entry counters and per-vector accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bands    <= '0;
            r_words    <= '0;
            r_lib_size <= '0;
            r_word_cnt <= '0;
            r_lib_cnt  <= '0;
            r_acc      <= '0;
        end else if (r_state == S_IDLE && w_start_pulse) begin
            r_bands    <= hsi_bands_in;
            r_words    <= (hsi_bands_in >> 1) + {{(BAND_W-1){1'b0}}, hsi_bands_in[0]};
            r_lib_size <= library_size_in;
            r_word_cnt <= '0;
            r_lib_cnt  <= '0;
            r_acc      <= '0;
        end else if (w_accept) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + BAND_W'(1);
            if (r_state == S_READ_LIB) begin
                r_acc <= w_last_word ? '0 : w_acc_next;
                if (w_last_word) r_lib_cnt <= r_lib_cnt + (LIB_W+1)'(1);
            end
        end
    end

    // Measure spectrum storage.
    always_ff @(posedge clk) begin
        if (w_accept && r_state == S_READ_MEASURE)
            r_meas_buf[r_word_cnt[ADDR_W-1:0]] <= hsi_vctr_in;
    end

    // Accumulated-sum FIFO payload.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_acc[r_wr_ptr] <= w_acc_next;
            r_fifo_idx[r_wr_ptr] <= r_lib_cnt[LIB_W-1:0];
        end
    end

    // Accumulated-sum FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + (FIFO_AW+1)'(1);
            else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - (FIFO_AW+1)'(1);
        end
    end

    // Sequential divider: load one FIFO entry, then one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_busy  <= 1'b0;
            r_div_cnt   <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
            r_div_idx   <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_mse   <= '0;
            r_cmp_idx   <= '0;
        end else begin
            r_cmp_valid <= 1'b0;
            if (w_pop) begin
                r_dq       <= r_fifo_acc[r_rd_ptr];
                r_div_idx  <= r_fifo_idx[r_rd_ptr];
                r_rem      <= '0;
                r_div_cnt  <= '0;
                r_div_busy <= 1'b1;
            end else if (r_div_busy) begin
                r_dq      <= w_dq_next;
                r_rem     <= w_rem_next;
                r_div_cnt <= r_div_cnt + DCNT_W'(1);
                if (r_div_cnt == DCNT_W'(DATA_WIDTH_ACC-1)) begin
                    r_div_busy  <= 1'b0;
                    r_cmp_valid <= 1'b1;
                    r_cmp_mse   <= w_quo_word;
                    r_cmp_idx   <= r_div_idx;
                end
            end
        end
    end

    // Min/max trackers; a clear or accepted start overrides a pending update.
    always_ff @(posedge clk) begin
        if (rst || w_init_trk) begin
            mse_min_value <= '1;
            mse_max_value <= '0;
            mse_min_ref   <= '0;
            mse_max_ref   <= '0;
        end else if (r_cmp_valid) begin
            if (r_cmp_idx == '0) begin
                mse_min_value <= r_cmp_mse;
                mse_max_value <= r_cmp_mse;
                mse_min_ref   <= '0;
                mse_max_ref   <= '0;
            end else begin
                if (r_cmp_mse < mse_min_value) begin
                    mse_min_value <= r_cmp_mse;
                    mse_min_ref   <= r_cmp_idx;
                end
                if (r_cmp_mse > mse_max_value) begin
                    mse_max_value <= r_cmp_mse;
                    mse_max_ref   <= r_cmp_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsid_main.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsid_main
// Description : Self-checking bench for hsid_main: table of small hand-worked
//               cases plus randomized runs against a software model, with
//               expected results queued at drive time and checked on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsid_main;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [31:0] din;
    logic [4:0]  lib_in;
    logic [7:0]  bands_in;
    logic        start;
    logic        clear;
    logic [3:0]  min_ref, max_ref;
    logic [31:0] min_val, max_val;
    logic        done, idle, ready;

    hsid_main dut (
        .clk               (clk),
        .rst               (rst),
        .hsi_vctr_in_valid (vld),
        .hsi_vctr_in       (din),
        .library_size_in   (lib_in),
        .hsi_bands_in      (bands_in),
        .start             (start),
        .clear             (clear),
        .mse_min_ref       (min_ref),
        .mse_max_ref       (max_ref),
        .mse_min_value     (min_val),
        .mse_max_value     (max_val),
        .done              (done),
        .idle              (idle),
        .ready             (ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [3:0]  mnr;
        logic [3:0]  mxr;
    } exp_t;

    typedef struct packed {
        logic [7:0]             bands;
        logic [4:0]             lib;
        logic [3:0][15:0]       meas;
        logic [3:0][3:0][15:0]  libv;
        exp_t                   exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    exp_t        sb [$];
    vec_t        tbl [0:5];
    logic [15:0] meas_s [0:127];
    logic [15:0] lib_s  [0:15][0:127];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] mn, input logic [31:0] mx,
                                    input int mnr, input int mxr);
        exp_t e;
        e.mn = mn; e.mx = mx; e.mnr = mnr[3:0]; e.mxr = mxr[3:0];
        return e;
    endfunction

    // Software reference: floor mean of squared differences, min/max with
    // earlier index winning ties and entry 0 seeding both trackers.
    function automatic exp_t model(input int bands, input int lib);
        exp_t r;
        r = mk_exp(32'hFFFF_FFFF, 32'h0, 0, 0);
        for (int e = 0; e < lib; e++) begin
            longint      s = 0;
            longint      q;
            logic [31:0] q32;
            for (int i = 0; i < bands; i++) begin
                int d = int'($signed(lib_s[e][i])) - int'($signed(meas_s[i]));
                s += longint'(d) * longint'(d);
            end
            q   = s / bands;
            q32 = q[31:0];
            if (e == 0) begin
                r.mn = q32; r.mx = q32; r.mnr = 0; r.mxr = 0;
            end else begin
                if (q32 < r.mn) begin r.mn = q32; r.mnr = e[3:0]; end
                if (q32 > r.mx) begin r.mx = q32; r.mxr = e[3:0]; end
            end
        end
        return r;
    endfunction

    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        vld = 1'b1;
        din = w;
        while (!ready && guard < 2000) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (guard >= 2000) begin
            errors++;
            $display("FAIL ready_timeout: ready stayed %0b, required 1", ready);
        end
        @(negedge clk);
    endtask

    task automatic run_case(input string name, input int bands, input int lib, input int hold);
        int   words = (bands + 1) / 2;
        int   g = 0;
        exp_t e;
        check({name, "_idle_before"}, {63'd0, idle}, 64'd1);
        check({name, "_ready_before"}, {63'd0, ready}, 64'd0);
        bands_in = bands[7:0];
        lib_in   = lib[4:0];
        start    = 1'b1;
        @(negedge clk);
        check({name, "_idle_after_start"}, {63'd0, idle}, 64'd0);
        check({name, "_ready_after_start"}, {63'd0, ready}, 64'd1);
        repeat (hold - 1) @(negedge clk);
        start  = 1'b0;
        stalls = 0;
        for (int k = 0; k < words; k++) send_word({meas_s[2*k+1], meas_s[2*k]});
        for (int j = 0; j < lib; j++)
            for (int k = 0; k < words; k++) send_word({lib_s[j][2*k+1], lib_s[j][2*k]});
        vld = 1'b0;
        while (!done && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%0b, required 1", name, done);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty: 0 entries, required 1", name);
        end else begin
            e = sb.pop_front();
            check({name, "_min_value"}, {32'd0, min_val}, {32'd0, e.mn});
            check({name, "_max_value"}, {32'd0, max_val}, {32'd0, e.mx});
            check({name, "_min_ref"},   {60'd0, min_ref}, {60'd0, e.mnr});
            check({name, "_max_ref"},   {60'd0, max_ref}, {60'd0, e.mxr});
            @(negedge clk);
            check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
            check({name, "_idle_after_done"}, {63'd0, idle}, 64'd1);
            check({name, "_min_hold"}, {32'd0, min_val}, {32'd0, e.mn});
        end
    endtask

    task automatic randomize_data(input int bands, input int lib);
        for (int i = 0; i < 128; i++) meas_s[i] = 16'($urandom);
        for (int j = 0; j < lib; j++)
            for (int i = 0; i < 128; i++) lib_s[j][i] = 16'($urandom);
        if (bands < 128) meas_s[bands] = 16'h7ABC;
    endtask

    task automatic check_cleared(input string name);
        check({name, "_min_value"}, {32'd0, min_val}, 64'hFFFF_FFFF);
        check({name, "_max_value"}, {32'd0, max_val}, 64'd0);
        check({name, "_min_ref"},   {60'd0, min_ref}, 64'd0);
        check({name, "_max_ref"},   {60'd0, max_ref}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{bands: 8'd4, lib: 5'd3, meas: mk(1, 2, 3, 4),
                   libv: {64'd0, mk(0, 0, 0, 0), mk(3, 4, 5, 6), mk(1, 2, 3, 4)},
                   exp: mk_exp(32'd0, 32'd7, 0, 2)};
        tbl[1] = '{bands: 8'd4, lib: 5'd3, meas: mk(0, 0, 0, 0),
                   libv: {64'd0, mk(3, -3, 3, -3), mk(-3, 3, -3, 3), mk(3, 3, 3, 3)},
                   exp: mk_exp(32'd9, 32'd9, 0, 0)};
        tbl[2] = '{bands: 8'd4, lib: 5'd0, meas: mk(5, 6, 7, 8),
                   libv: '0,
                   exp: mk_exp(32'hFFFF_FFFF, 32'd0, 0, 0)};
        tbl[3] = '{bands: 8'd3, lib: 5'd2, meas: mk(10, 0, 0, 16'h1234),
                   libv: {64'd0, 64'd0, mk(0, 0, 0, 555), mk(10, 0, 3, 999)},
                   exp: mk_exp(32'd3, 32'd33, 0, 1)};
        tbl[4] = '{bands: 8'd2, lib: 5'd2, meas: mk(-32768, 32767, 0, 0),
                   libv: {64'd0, 64'd0, mk(-32768, 32767, 0, 0), mk(32767, -32768, 0, 0)},
                   exp: mk_exp(32'd0, 32'hFFFE_0001, 1, 0)};
        tbl[5] = '{bands: 8'd2, lib: 5'd4, meas: mk(0, 0, 0, 0),
                   libv: {mk(0, 0, 0, 0), mk(2, 0, 0, 0), mk(2, 0, 0, 0), mk(4, 0, 0, 0)},
                   exp: mk_exp(32'd0, 32'd8, 3, 0)};

        rst = 1'b1; vld = 1'b0; din = '0; lib_in = '0; bands_in = 8'd2;
        start = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_idle",  {63'd0, idle},  64'd1);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_done",  {63'd0, done},  64'd0);
        check_cleared("reset");

        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 4; i++) meas_s[i] = tbl[c].meas[i];
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++) lib_s[j][i] = tbl[c].libv[j][i];
            sb.push_back(tbl[c].exp);
            run_case($sformatf("table%0d", c), int'(tbl[c].bands), int'(tbl[c].lib), (c == 1) ? 3 : 1);
        end

        randomize_data(128, 10);
        sb.push_back(model(128, 10));
        run_case("rand_b128_l10", 128, 10, 1);
        check("rand_b128_no_stall", 64'(stalls), 64'd0);

        randomize_data(127, 4);
        sb.push_back(model(127, 4));
        run_case("rand_b127_l4", 127, 4, 1);

        randomize_data(2, 16);
        sb.push_back(model(2, 16));
        run_case("rand_b2_l16", 2, 16, 1);
        $display("info: b2_l16 ready-low cycles = %0d", stalls);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_cleared("clear");

        randomize_data(16, 3);
        bands_in = 8'd16; lib_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) send_word({meas_s[2*k+1], meas_s[2*k]});
        vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_idle",  {63'd0, idle},  64'd1);
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check_cleared("midrst");

        randomize_data(6, 5);
        sb.push_back(model(6, 5));
        run_case("after_rst", 6, 5, 1);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
